// File: rtl/mux41_rr_arbiter_pkg.sv
// Shared definitions for the 4:1 mux round-robin arbiter: FSM encodings,
// mux input identifiers and a small one-hot helper.
package mux41_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN  = 2'd1
   } state_t;

   localparam logic [1:0] ID_A = 2'd0;
   localparam logic [1:0] ID_B = 2'd1;
   localparam logic [1:0] ID_C = 2'd2;
   localparam logic [1:0] ID_D = 2'd3;

   function automatic logic [3:0] id2onehot(input logic [1:0] id);
      return 4'b0001 << id;
   endfunction

endpackage

// File: rtl/mux41_rr_arbiter_if.sv
// Request/grant bundle between the four requesters and the arbiter,
// including the mux tree select lines the arbiter drives.
interface mux41_rr_arbiter_if;

   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       busy;
   logic       s00;
   logic       s01;
   logic       s1;

   modport master (
      output req,
      input  gnt, gnt_id, busy, s00, s01, s1
   );

   modport slave (
      input  req,
      output gnt, gnt_id, busy, s00, s01, s1
   );

endinterface

// File: rtl/mux41_rr_arbiter_rr_pick4.sv
// Combinational round-robin search: first set bit of req at or after start,
// wrapping modulo 4.
module rr_pick4 (
   input  logic [3:0] req,
   input  logic [1:0] start,
   output logic [1:0] id,
   output logic       found
);

   logic [1:0] idx_s;

   // Walk the four offsets from start; the first hit wins.
   always_comb begin
      id    = 2'd0;
      found = 1'b0;
      idx_s = start;
      for (int k = 0; k < 4; k++) begin
         idx_s = start + 2'(k);
         id    = (!found && req[idx_s]) ? idx_s : id;
         found = found | req[idx_s];
      end
   end

endmodule

// File: rtl/mux41_rr_arbiter.sv
// Round-robin arbiter for the shared 4:1 mux tree with bounded tenure under
// contention; grant and select lines are all registered.
module mux41_rr_arbiter
   import mux41_pkg::*;
#(
   parameter int MAX_HOLD = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   mux41_rr_arbiter_if.slave   bus
);

   localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

   state_t     state_r, state_nxt_s;
   logic [3:0] cnt_r, cnt_nxt_s;
   logic [1:0] last_r, last_nxt_s;
   logic [3:0] gnt_r, gnt_nxt_s;
   logic [1:0] gnt_id_r, id_nxt_s;
   logic       busy_r, busy_nxt_s;
   logic       s00_r, s00_nxt_s;
   logic       s01_r, s01_nxt_s;
   logic       s1_r, s1_nxt_s;

   logic [1:0] start_idle_s, start_hand_s;
   logic [1:0] id_idle_s, id_hand_s;
   logic       found_idle_s, found_hand_s;
   logic [3:0] others_s;
   logic       owner_req_s;
   logic       hold_max_s;

   assign start_idle_s = last_r + 2'd1;
   assign start_hand_s = gnt_id_r + 2'd1;
   // The owner's own bit is masked so handoff/rotation never re-picks it.
   assign others_s     = bus.req & ~id2onehot(gnt_id_r);
   assign owner_req_s  = bus.req[gnt_id_r];
   assign hold_max_s   = (cnt_r >= MAX_HOLD_C);

   rr_pick4 u_pick_idle (
      .req   (bus.req),
      .start (start_idle_s),
      .id    (id_idle_s),
      .found (found_idle_s)
   );

   rr_pick4 u_pick_hand (
      .req   (others_s),
      .start (start_hand_s),
      .id    (id_hand_s),
      .found (found_hand_s)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; illegal encodings fall back to IDLE.
   always_comb begin
      state_nxt_s = ST_IDLE;
      case (state_r)
         ST_IDLE: begin
            if (found_idle_s) begin
               state_nxt_s = ST_OWN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_OWN: begin
            if (owner_req_s || found_hand_s) begin
               state_nxt_s = ST_OWN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Next owner, tenure counter and pointer for the registered outputs.
   always_comb begin
      busy_nxt_s = 1'b0;
      id_nxt_s   = ID_A;
      cnt_nxt_s  = 4'd0;
      last_nxt_s = last_r;
      case (state_r)
         ST_IDLE: begin
            if (found_idle_s) begin
               busy_nxt_s = 1'b1;
               id_nxt_s   = id_idle_s;
               cnt_nxt_s  = 4'd1;
               last_nxt_s = id_idle_s;
            end else begin
               busy_nxt_s = 1'b0;
            end
         end
         ST_OWN: begin
            if ((!owner_req_s || hold_max_s) && found_hand_s) begin
               busy_nxt_s = 1'b1;
               id_nxt_s   = id_hand_s;
               cnt_nxt_s  = 4'd1;
               last_nxt_s = id_hand_s;
            end else if (!owner_req_s) begin
               busy_nxt_s = 1'b0;
            end else if (hold_max_s) begin
               busy_nxt_s = 1'b1;
               id_nxt_s   = gnt_id_r;
               cnt_nxt_s  = MAX_HOLD_C;
            end else begin
               busy_nxt_s = 1'b1;
               id_nxt_s   = gnt_id_r;
               cnt_nxt_s  = cnt_r + 4'd1;
            end
         end
         default: begin
            busy_nxt_s = 1'b0;
         end
      endcase
      gnt_nxt_s = busy_nxt_s ? id2onehot(id_nxt_s) : 4'b0000;
      s00_nxt_s = busy_nxt_s && (id_nxt_s == ID_B);
      s01_nxt_s = busy_nxt_s && (id_nxt_s == ID_D);
      s1_nxt_s  = busy_nxt_s && id_nxt_s[1];
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r    <= 4'd0;
         last_r   <= ID_D;
         gnt_r    <= 4'b0000;
         gnt_id_r <= ID_A;
         busy_r   <= 1'b0;
         s00_r    <= 1'b0;
         s01_r    <= 1'b0;
         s1_r     <= 1'b0;
      end else begin
         cnt_r    <= cnt_nxt_s;
         last_r   <= last_nxt_s;
         gnt_r    <= gnt_nxt_s;
         gnt_id_r <= id_nxt_s;
         busy_r   <= busy_nxt_s;
         s00_r    <= s00_nxt_s;
         s01_r    <= s01_nxt_s;
         s1_r     <= s1_nxt_s;
      end
   end

   assign bus.gnt    = gnt_r;
   assign bus.gnt_id = gnt_id_r;
   assign bus.busy   = busy_r;
   assign bus.s00    = s00_r;
   assign bus.s01    = s01_r;
   assign bus.s1     = s1_r;

endmodule

// File: tb/tb_mux41_rr_arbiter.sv
// Bench for mux41_rr_arbiter: directed scenarios plus random requests, with
// two instances (MAX_HOLD 8 and 1) checked against a behavioural model.
module tb_mux41_rr_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   mux41_rr_arbiter_if if8 ();
   mux41_rr_arbiter_if if1 ();

   mux41_rr_arbiter #(.MAX_HOLD(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
   mux41_rr_arbiter #(.MAX_HOLD(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Model state per instance: 0 -> MAX_HOLD 8, 1 -> MAX_HOLD 1.
   int m_busy [2];
   int m_owner[2];
   int m_cnt  [2];
   int m_last [2];
   int m_hold [2] = '{8, 1};

   function automatic int rr_find(input logic [3:0] r, input int start, input int excl);
      for (int k = 0; k < 4; k++) begin
         int idx = (start + k) % 4;
         if (r[idx] && idx != excl) return idx;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_busy[d] = 0; m_owner[d] = 0; m_cnt[d] = 0; m_last[d] = 3;
      end
   endtask

   task automatic grant_to(input int d, input int w);
      m_busy[d] = 1; m_owner[d] = w; m_cnt[d] = 1; m_last[d] = w;
   endtask

   task automatic model_step(input int d, input logic [3:0] r);
      int w;
      if (m_busy[d] == 0) begin
         w = rr_find(r, m_last[d] + 1, -1);
         if (w >= 0) grant_to(d, w);
      end else if (!r[m_owner[d]]) begin
         w = rr_find(r, m_owner[d] + 1, m_owner[d]);
         if (w >= 0) grant_to(d, w);
         else begin m_busy[d] = 0; m_owner[d] = 0; m_cnt[d] = 0; end
      end else if (m_cnt[d] >= m_hold[d]) begin
         w = rr_find(r, m_owner[d] + 1, m_owner[d]);
         if (w >= 0) grant_to(d, w);
      end else begin
         m_cnt[d] = m_cnt[d] + 1;
      end
   endtask

   function automatic logic [9:0] exp_vec(input int d);
      logic b;
      b = (m_busy[d] != 0);
      return {b ? (4'b0001 << m_owner[d]) : 4'b0000,
              b ? 2'(m_owner[d]) : 2'd0,
              b,
              b && m_owner[d] == 1,
              b && m_owner[d] == 3,
              b && m_owner[d] >= 2};
   endfunction

   function automatic logic [9:0] obs8();
      return {if8.gnt, if8.gnt_id, if8.busy, if8.s00, if8.s01, if8.s1};
   endfunction

   function automatic logic [9:0] obs1();
      return {if1.gnt, if1.gnt_id, if1.busy, if1.s00, if1.s01, if1.s1};
   endfunction

   task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_step(0, if8.req);
      model_step(1, if1.req);
      #1;
      check({tag, "_h8"}, obs8(), exp_vec(0));
      check({tag, "_h1"}, obs1(), exp_vec(1));
   endtask

   initial begin
      logic [1:0] prev_id;
      int run;
      if8.req = 4'b0000;
      if1.req = 4'b0000;
      model_reset();
      #12;
      check("reset_h8", obs8(), 10'b0);
      check("reset_h1", obs1(), 10'b0);
      rst_n = 1'b1;

      // Single requester 2, then release.
      if8.req = 4'b0100;
      tick("grant");
      check("grant_c", obs8(), 10'b0100_10_1_0_0_1);
      if8.req = 4'b0000;
      tick("release");
      check("release_c", obs8(), 10'b0);

      // Full contention: every tenure must be MAX_HOLD cycles.
      if8.req = 4'b1111;
      run = 0;
      prev_id = 2'd0;
      for (int i = 0; i < 40; i++) begin
         tick("contend");
         if (run > 0 && if8.gnt_id == prev_id) begin
            run++;
         end else begin
            if (run > 0) check("tenure", 10'(run), 10'd8);
            run = 1;
            prev_id = if8.gnt_id;
         end
      end

      // Lone requester keeps the grant indefinitely.
      if8.req = 4'b0001;
      for (int i = 0; i < 20; i++) begin
         tick("solo");
         check("solo_c", obs8(), 10'b0001_00_1_0_0_0);
      end

      // Direct handoff from owner 1 to requester 3.
      if8.req = 4'b0010;
      tick("to1");
      if8.req = 4'b1010;
      for (int i = 0; i < 3; i++) tick("own1");
      check("own1_c", obs8(), 10'b0010_01_1_1_0_0);
      if8.req = 4'b1000;
      tick("handoff");
      check("handoff_c", obs8(), 10'b1000_11_1_0_1_1);

      // Asynchronous reset in the middle of a grant.
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      check("async_rst_h8", obs8(), 10'b0);
      check("async_rst_h1", obs1(), 10'b0);
      @(negedge clk);
      rst_n = 1'b1;
      if8.req = 4'b1111;
      tick("after_rst");
      check("after_rst_c", obs8(), 10'b0001_00_1_0_0_0);

      // MAX_HOLD=1 rotates every cycle between 0 and 1.
      if8.req = 4'b0000;
      if1.req = 4'b0011;
      for (int i = 0; i < 8; i++) begin
         tick("alt");
         check("alt_c", {8'b0, if1.gnt_id}, 10'(i % 2));
      end

      // Random request traffic on both instances.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) if8.req = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) if1.req = 4'($urandom_range(0, 15));
         tick("rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
